// File: rtl/hv_bundle_acc512.sv
// Bundling (majority-vote) accumulator: one signed saturating counter per bit
// of a C-bit bipolar chunk; the sign-thresholded chunk is emitted on bundle close.

// Per-bit lane: signed saturating up/down counter plus the threshold of its next value.
module hv_bundle_acc512_lane #(
  parameter int CNT_BITS = 8,
  parameter int TIE_ONE  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic upd_i,
  input  logic bit_i,
  output logic thr_o
);
  localparam logic signed [CNT_BITS-1:0] CMAX = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic signed [CNT_BITS-1:0] CMIN = -CMAX;
  localparam logic signed [CNT_BITS-1:0] ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic signed [CNT_BITS-1:0] cnt_q, cnt_d;

  // Next count: clear wins, else step toward the chunk bit, clamped symmetric
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (upd_i) begin
      if (bit_i) begin
        if (cnt_q != CMAX) cnt_d = cnt_q + ONE;
      end else begin
        if (cnt_q != CMIN) cnt_d = cnt_q - ONE;
      end
    end
  end

  // Threshold the post-update value so the closing chunk is included
  always_comb begin
    if (cnt_d == '0)             thr_o = (TIE_ONE != 0);
    else if (cnt_d[CNT_BITS-1])  thr_o = 1'b0;
    else                         thr_o = 1'b1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

module hv_bundle_acc512 #(
  parameter int C        = 512,
  parameter int CNT_BITS = 8,
  parameter int N_BITS   = 16,
  parameter int TIE_ONE  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [C-1:0]      in_chunk,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [C-1:0]      out_chunk,
  output logic [N_BITS-1:0] out_n
);
  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [N_BITS-1:0]   n_q, n_d, n_inc;
  logic [C-1:0]        out_chunk_q, out_chunk_d;
  logic [N_BITS-1:0]   out_n_q, out_n_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                cnt_clr, cnt_upd;
  logic [C-1:0]        thr;

  // One counter lane per bit position
  for (genvar i = 0; i < C; i++) begin : g_lane
    hv_bundle_acc512_lane #(.CNT_BITS(CNT_BITS), .TIE_ONE(TIE_ONE)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .upd_i (cnt_upd),
      .bit_i (in_chunk[i]),
      .thr_o (thr[i])
    );
  end

  assign n_inc = (n_q == {N_BITS{1'b1}}) ? n_q : n_q + 1'b1;

  // Next-state, counter control and output staging; clr overrides everything
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    out_chunk_d = out_chunk_q;
    out_n_d     = out_n_q;
    cnt_clr     = 1'b0;
    cnt_upd     = 1'b0;
    if (clr) begin
      state_d     = ACCUM;
      n_d         = '0;
      out_chunk_d = '0;
      out_n_d     = '0;
      cnt_clr     = 1'b1;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            cnt_upd = 1'b1;
            n_d     = n_inc;
            if (in_last) begin
              state_d     = EMIT;
              out_chunk_d = thr;
              out_n_d     = n_inc;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_d     = ACCUM;
            n_d         = '0;
            out_chunk_d = '0;
            out_n_d     = '0;
            cnt_clr     = 1'b1;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == EMIT);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      n_q         <= '0;
      out_chunk_q <= '0;
      out_n_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      out_chunk_q <= out_chunk_d;
      out_n_q     <= out_n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_chunk = out_chunk_q;
  assign out_n     = out_n_q;
endmodule

// File: tb/tb_hv_bundle_acc512.sv
// Bench: two instances (default config, and CNT_BITS=4/TIE_ONE=0) driven with the
// same stream; a per-bit integer model predicts handshakes and thresholded chunks.
module tb_hv_bundle_acc512;
  localparam int C = 512;

  logic          clk = 1'b0;
  logic          rst_n, clr, in_valid, in_last, out_ready;
  logic [C-1:0]  in_chunk;
  logic          in_ready8, out_valid8, in_ready4, out_valid4;
  logic [C-1:0]  out_chunk8, out_chunk4;
  logic [15:0]   out_n8, out_n4;

  always #5 clk = ~clk;

  hv_bundle_acc512 u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready8),
    .in_chunk(in_chunk), .in_last(in_last), .out_valid(out_valid8),
    .out_ready(out_ready), .out_chunk(out_chunk8), .out_n(out_n8)
  );

  hv_bundle_acc512 #(.C(C), .CNT_BITS(4), .N_BITS(16), .TIE_ONE(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready4),
    .in_chunk(in_chunk), .in_last(in_last), .out_valid(out_valid4),
    .out_ready(out_ready), .out_chunk(out_chunk4), .out_n(out_n4)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [C-1:0] got, input logic [C-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: plain integer tallies per bit, clamped at +-lim
  int          cnt8 [C];
  int          cnt4 [C];
  int          m_n;
  bit          m_emit;
  logic [C-1:0] e8, e4;
  int          e_n;

  function automatic int clampi(input int v, input int lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < C; i++) begin cnt8[i] = 0; cnt4[i] = 0; end
    m_n = 0; m_emit = 0; e8 = '0; e4 = '0; e_n = 0;
  endtask

  task automatic m_step(input logic r, c, v, input logic [C-1:0] d, input logic l, o);
    if (!r || c) m_clear();
    else if (m_emit) begin
      if (o) m_clear();
    end else if (v) begin
      for (int i = 0; i < C; i++) begin
        cnt8[i] = clampi(cnt8[i] + (d[i] ? 1 : -1), 127);
        cnt4[i] = clampi(cnt4[i] + (d[i] ? 1 : -1), 7);
      end
      if (m_n < 65535) m_n++;
      if (l) begin
        m_emit = 1;
        e_n = m_n;
        for (int i = 0; i < C; i++) begin
          e8[i] = (cnt8[i] >= 0);
          e4[i] = (cnt4[i] > 0);
        end
      end
    end
  endtask

  // One clock: drive, advance, update model, then compare after the edge
  task automatic cyc(input logic r, c, v, input logic [C-1:0] d, input logic l, o);
    rst_n = r; clr = c; in_valid = v; in_chunk = d; in_last = l; out_ready = o;
    @(posedge clk);
    m_step(r, c, v, d, l, o);
    #1;
    chk("in_ready",  in_ready8,  !m_emit);
    chk("out_valid", out_valid8, m_emit);
    chk("in_ready4", in_ready4,  !m_emit);
    if (m_emit) begin
      chk("out_chunk",  out_chunk8, e8);
      chk("out_chunk4", out_chunk4, e4);
      chk("out_n",      out_n8,     e_n);
      chk("out_n4",     out_n4,     e_n);
    end
  endtask

  function automatic logic [C-1:0] rnd_chunk();
    logic [C-1:0] x;
    for (int i = 0; i < C/32; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  localparam logic [C-1:0] ONES = {C{1'b1}};
  localparam logic [C-1:0] ZERO = {C{1'b0}};
  logic [127:0] pat;
  logic [C-1:0] a_pat;

  initial begin
    m_clear();
    pat = 128'hDEADBEEF_CAFEBABE_12345678_9ABCDEF0;
    a_pat = {4{pat}};

    // Reset state
    cyc(0, 0, 0, ZERO, 0, 0);
    cyc(0, 0, 0, ZERO, 0, 0);
    chk("rst_chunk", out_chunk8, ZERO);
    chk("rst_n", out_n8, 0);

    // All-ones bundle of 3
    cyc(1, 0, 1, ONES, 0, 0);
    cyc(1, 0, 1, ONES, 0, 0);
    cyc(1, 0, 1, ONES, 1, 0);
    chk("ones_chunk", out_chunk8, ONES);
    chk("ones_n", out_n8, 3);
    cyc(1, 0, 0, ZERO, 0, 1);

    // Tie: +1 then -1 -> zero counters
    cyc(1, 0, 1, ONES, 0, 0);
    cyc(1, 0, 1, ZERO, 1, 0);
    chk("tie_one", out_chunk8, ONES);
    chk("tie_zero", out_chunk4, ZERO);
    chk("tie_n", out_n8, 2);
    cyc(1, 0, 0, ZERO, 0, 1);

    // Saturation: 10 up then 8 down; 4-bit counter clamps at 7 so ends at -1
    for (int k = 0; k < 10; k++) cyc(1, 0, 1, ONES, 0, 0);
    for (int k = 0; k < 8; k++)  cyc(1, 0, 1, ZERO, k == 7, 0);
    chk("sat4_chunk", out_chunk4, ZERO);
    chk("sat8_chunk", out_chunk8, ONES);
    chk("sat_n", out_n4, 18);
    cyc(1, 0, 0, ZERO, 0, 1);

    // Majority A, A, ~A
    cyc(1, 0, 1, a_pat, 0, 0);
    cyc(1, 0, 1, a_pat, 0, 0);
    cyc(1, 0, 1, ~a_pat, 1, 0);
    chk("maj_chunk", out_chunk8, a_pat);
    chk("maj_pop", $countones(~(out_chunk8 ^ a_pat)), 512);
    chk("maj_n", out_n8, 3);
    cyc(1, 0, 0, ZERO, 0, 1);

    // Backpressure: result held 5 cycles with input offered and ignored
    cyc(1, 0, 1, ONES, 1, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, rnd_chunk(), 0, 0);
    chk("bp_hold", out_chunk8, ONES);
    chk("bp_n", out_n8, 1);
    cyc(1, 0, 1, ONES, 0, 1);
    cyc(1, 0, 1, ZERO, 1, 0);
    chk("bp_fresh", out_chunk8, ZERO);
    chk("bp_fresh_n", out_n8, 1);
    cyc(1, 0, 0, ZERO, 0, 1);

    // Abort mid-bundle; chunk offered with clr is discarded
    cyc(1, 0, 1, ONES, 0, 0);
    cyc(1, 0, 1, ONES, 0, 0);
    cyc(1, 1, 1, ONES, 0, 0);
    cyc(1, 0, 1, ZERO, 1, 0);
    chk("clr_chunk", out_chunk8, ZERO);
    chk("clr_n", out_n8, 1);

    // Reset while a result is pending
    cyc(0, 0, 0, ZERO, 0, 0);
    chk("rst_ov", out_valid8, 0);
    chk("rst_ir", in_ready8, 1);
    chk("rst_on", out_n8, 0);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      logic r, c, v, l, o;
      r = ($urandom_range(0, 199) != 0);
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 9) < 2);
      o = ($urandom_range(0, 9) < 6);
      cyc(r, c, v, rnd_chunk(), l, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hv_bundle_acc512.md
# hv_bundle_acc512

Bundling (majority-vote) accumulator for the HTC weight write path. It consumes a stream of C-bit bipolar HV chunks and keeps one signed saturating counter per bit position. On the last chunk of a bundle it emits the sign-thresholded chunk as a new weight/attractor chunk. This block produces the weight chunks that the XNOR-popcount similarity engines later read.

## Interface

Parameters:
- C, 512: chunk width in bits.
- CNT_BITS, 8: width of each signed per-bit counter; saturates at ±(2^(CNT_BITS-1)-1).
- N_BITS, 16: width of the bundled-sample count output.
- TIE_ONE, 1: output bit value when a counter is exactly 0.

Ports:
- clk  in  1: clock; all state changes on its rising edge.
- rst_n  in  1: reset, synchronous, active-low.
- clr  in  1: synchronous abort/clear of the current bundle.
- in_valid  in  1: an input chunk is presented.
- in_ready  out  1: block accepts an input chunk.
- in_chunk  in  C: bipolar HV chunk (1 = +1, 0 = -1).
- in_last  in  1: the accepted chunk closes the bundle.
- out_valid  out  1: the result chunk is valid.
- out_ready  in  1: the consumer accepts the result.
- out_chunk  out  C: thresholded weight chunk.
- out_n  out  N_BITS: number of chunks in the emitted bundle.

## Operation

- States:
  - ACCUM (reset state): in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Input handshake: a chunk is accepted when in_valid && in_ready.
- On acceptance, for every bit i:
  - cnt[i] += +1 if in_chunk[i]=1, else -1.
  - The counter saturates at +(2^(CNT_BITS-1)-1) and -(2^(CNT_BITS-1)-1). The most-negative code is never reached.
- Sample count: n increments on each acceptance and saturates at 2^N_BITS-1.
- Bundle close: an acceptance with in_last=1 applies that chunk's update, then moves ACCUM→EMIT.
- Output value in EMIT: out_chunk[i] = 1 if cnt[i]>0, 0 if cnt[i]<0, TIE_ONE if cnt[i]==0. out_n = n.
- Output handshake: out_valid && out_ready moves EMIT→ACCUM, clears all counters and n to 0.
- clr, in any state:
  - Next state is ACCUM; counters and n are cleared.
  - A chunk accepted in the same cycle is discarded.
  - A pending result is dropped.
  - rst_n has priority over clr.
- An in_last with only one chunk is legal: the bundle is emitted with n=1.
- in_valid while in EMIT is ignored (in_ready=0). The producer must hold the chunk until it is accepted.
- out_chunk and out_n are stable while out_valid=1 and out_ready=0.

## Timing

- Reset (rst_n=0 at an edge), next cycle:
  - State is ACCUM, all counters are 0, n=0.
  - in_ready=1, out_valid=0, out_chunk=0, out_n=0.
- Acceptance at edge k: the counter update is visible from edge k.
- in_last accepted at edge k: out_valid=1 in cycle k+1. out_chunk includes the last chunk.
- Output handshake at edge m: in_ready=1 and counters=0 in cycle m+1.
  - No input can be accepted in the same cycle as the output handshake.
  - Minimum bundle-to-bundle gap is therefore one cycle of in_ready=0 per bundle.
- Throughput in ACCUM: one chunk per cycle.
- Registered outputs: in_ready, out_valid, out_chunk and out_n come directly from flops, with no combinational paths from inputs.
- The threshold is computed from the counters in the EMIT-entry cycle and registered into out_chunk.
- Mid-operation reset behaves exactly like power-up reset. Any partial bundle or pending result is discarded.

## Test plan

- **All-ones bundle:** reset, then 3 chunks of all-ones with in_last on the 3rd → out_valid one cycle later, out_chunk = all-ones, out_n=3.
- **Tie resolution:** one all-ones chunk then one all-zeros chunk (last), TIE_ONE=1 → out_chunk = all-ones, out_n=2. Repeat with TIE_ONE=0 → all-zeros.
- **Saturation:** CNT_BITS=4. Send 10 all-ones chunks then 8 all-zeros chunks (last).
  - Required: out_chunk = all-zeros (counter goes 7→-1), out_n=18.
  - Without saturation the result would be all-ones.
- **Majority pattern:** chunks A, A, B (last), with A = DEADBEEF_CAFEBABE_12345678_9ABCDEF0 repeated and B = ~A.
  - Required: out_chunk == A, out_n=3.
  - Feeding out_chunk and A into the XNOR-popcount engine yields popcnt=512.
- **Backpressure:** hold out_ready=0 for 5 cycles after a bundle closes, with in_valid=1 throughout.
  - During those cycles: out_valid stays 1, out_chunk is stable, in_ready=0, and no samples are counted.
  - On raising out_ready: in_ready=1 the next cycle, and the next bundle starts from zero counters.
- **Abort and reset:**
  - Assert clr after 2 of 4 chunks; the next bundle (1 all-zeros chunk, last) gives out_chunk = all-zeros, out_n=1.
  - Assert rst_n=0 while out_valid=1; the next cycle gives out_valid=0, in_ready=1, out_n=0.
